ifu_fetch: RTL and testbench

Instruction fetch unit and IF/ID pipeline register for the pipelined MIPS core. It holds the PC, drives the word address to the instruction memory, and captures the returned instruction into the decode stage. It applies stall, flush and branch/jump redirects from the hazard and decode logic, and flags fetch address errors. The instruction memory is combinational and word-indexed from the code base address.

---
 rtl/ifu_fetch_if.sv | 25 ++
 rtl/ifu_fetch.sv | 70 +++++++
 tb/tb_ifu_fetch.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-side signal bundle between the hazard/decode logic, the instruction memory and ifu_fetch.
// Control and memory data flow toward the fetch unit; fetch address and D-stage state flow back.
interface ifu_fetch_if;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] im_addr;
   logic [31:0] instr;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        valid_d;
   logic        adel_d;

   modport master (
      output stall, flush, redirect, target, instr,
      input  im_addr, instr_d, pc_d, pc8_d, valid_d, adel_d
   );

   modport slave (
      input  stall, flush, redirect, target, instr,
      output im_addr, instr_d, pc_d, pc8_d, valid_d, adel_d
   );
endinterface

// File: rtl/ifu_fetch.sv
// PC register plus IF/ID pipeline register; fetch latency 1 cycle (im_addr in cycle n lands in D at edge n).
// stall holds PC and D and parks any redirect until the first unstalled edge; flush inserts a bubble in D.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input logic       clk,
   input logic       reset,
   ifu_fetch_if.slave fi
);

   localparam logic [31:0] PC_LAST = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;

   logic [31:0] pc_f;
   logic [31:0] pend_t;
   logic        pend_v;
   logic        adel_f;

   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic        valid_d;
   logic        adel_d;

   assign adel_f = (pc_f[1:0] != 2'b00) | (pc_f < RESET_PC) | (pc_f > PC_LAST);

   // A redirect seen during a stall is parked so it survives the redirect source dropping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_f   <= RESET_PC;
         pend_v <= 1'b0;
         pend_t <= 32'h0;
      end else if (fi.stall) begin
         if (fi.redirect) begin
            pend_v <= 1'b1;
            pend_t <= fi.target;
         end
      end else if (fi.redirect) begin
         pc_f   <= fi.target;
         pend_v <= 1'b0;
      end else if (pend_v) begin
         pc_f   <= pend_t;
         pend_v <= 1'b0;
      end else begin
         pc_f   <= pc_f + 32'd4;
      end
   end

   // Memory data is never trusted for an illegal fetch; D receives a nop instead.
   always_ff @(posedge clk) begin
      if (!reset || fi.flush) begin
         instr_d <= 32'h0;
         pc_d    <= RESET_PC;
         valid_d <= 1'b0;
         adel_d  <= 1'b0;
      end else if (!fi.stall) begin
         instr_d <= adel_f ? 32'h0 : fi.instr;
         pc_d    <= pc_f;
         valid_d <= 1'b1;
         adel_d  <= adel_f;
      end
   end

   assign fi.im_addr = pc_f;
   assign fi.instr_d = instr_d;
   assign fi.pc_d    = pc_d;
   assign fi.pc8_d   = pc_d + 32'd8;
   assign fi.valid_d = valid_d;
   assign fi.adel_d  = adel_d;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios then random control traffic, compared each cycle to a queue-based model.
module tb_ifu_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam int          IM_WORDS = 4096;

   logic clk;
   logic reset;

   ifu_fetch_if fi();

   ifu_fetch #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) dut (
      .clk   (clk),
      .reset (reset),
      .fi    (fi)
   );

   logic [31:0] mem [IM_WORDS];

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: the architectural fetch PC, what D holds, and parked redirect targets.
   logic [31:0] m_pc;
   logic [31:0] m_instr_d;
   logic [31:0] m_pc_d;
   logic        m_valid_d;
   logic        m_adel_d;
   logic [31:0] m_pend [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic bad_addr(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(RESET_PC);
      return (a % 4 != 0) || (off < 0) || (off >= 4 * longint'(IM_WORDS));
   endfunction

   // Illegal addresses return garbage so a design that forwards it gets caught.
   function automatic logic [31:0] imem(input logic [31:0] a);
      if (bad_addr(a)) return a ^ 32'hBADC_0DE5;
      return mem[int'((a - RESET_PC) / 4)];
   endfunction

   always_comb fi.instr = imem(fi.im_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic check_all();
      chk("im_addr", fi.im_addr, m_pc);
      chk("instr_d", fi.instr_d, m_instr_d);
      chk("pc_d",    fi.pc_d,    m_pc_d);
      chk("pc8_d",   fi.pc8_d,   m_pc_d + 32'd8);
      chk("valid_d", {31'b0, fi.valid_d}, {31'b0, m_valid_d});
      chk("adel_d",  {31'b0, fi.adel_d},  {31'b0, m_adel_d});
   endtask

   // Apply one cycle of inputs, advance the model by the behavioural rules, then compare.
   task automatic cycle(input logic rst_n, input logic s, input logic f,
                        input logic r, input logic [31:0] t);
      reset       = rst_n;
      fi.stall    = s;
      fi.flush    = f;
      fi.redirect = r;
      fi.target   = t;
      if (!rst_n || f) begin
         m_instr_d = 32'h0;
         m_pc_d    = RESET_PC;
         m_valid_d = 1'b0;
         m_adel_d  = 1'b0;
      end else if (!s) begin
         m_pc_d    = m_pc;
         m_valid_d = 1'b1;
         m_adel_d  = bad_addr(m_pc);
         m_instr_d = bad_addr(m_pc) ? 32'h0 : imem(m_pc);
      end
      if (!rst_n) begin
         m_pc = RESET_PC;
         m_pend.delete();
      end else if (s) begin
         if (r) begin
            m_pend.delete();
            m_pend.push_back(t);
         end
      end else if (r) begin
         m_pc = t;
         m_pend.delete();
      end else if (m_pend.size() > 0) begin
         m_pc = m_pend.pop_front();
      end else begin
         m_pc = m_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic jump(input logic [31:0] t);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, t);
   endtask

   initial begin
      logic [31:0] t;
      logic s, f, r, rn;
      for (int i = 0; i < IM_WORDS; i++) mem[i] = $urandom | 32'h1;
      reset = 1'b0;
      fi.stall = 1'b0; fi.flush = 1'b0; fi.redirect = 1'b0; fi.target = 32'h0;
      m_pc = 32'hFFFF_FFFF; m_instr_d = 32'hFFFF_FFFF; m_pc_d = 32'hFFFF_FFFF;
      m_valid_d = 1'b1; m_adel_d = 1'b1;

      // Reset state, then sequential fetch.
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst_im_addr", fi.im_addr, 32'h0000_3000);
      chk("rst_pc8_d", fi.pc8_d, 32'h0000_3008);
      idle();
      chk("rel_pc_d", fi.pc_d, 32'h0000_3000);
      idle();

      // Branch in D at 0x3004: slot 0x3008 enters D, then target fetched.
      jump(32'h0000_3040);
      chk("slot_pc_d", fi.pc_d, 32'h0000_3008);
      chk("br_im_addr", fi.im_addr, 32'h0000_3040);
      idle();
      chk("br_pc_d", fi.pc_d, 32'h0000_3040);

      // Two-cycle stall at 0x3010 with redirect only in the first stall cycle.
      jump(32'h0000_3010);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3100);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_im_addr", fi.im_addr, 32'h0000_3010);
      idle();
      chk("pend_im_addr", fi.im_addr, 32'h0000_3100);
      idle();

      // flush beats stall; PC unchanged.
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("flush_valid", {31'b0, fi.valid_d}, 32'h0);
      idle();

      // Misaligned and out-of-range fetches.
      jump(32'h0000_3002);
      idle();
      chk("mis_adel", {31'b0, fi.adel_d}, 32'h1);
      jump(32'h0000_7000);
      idle();
      chk("oor_pc_d", fi.pc_d, 32'h0000_7000);
      idle();

      // PC wrap past the top of the address space.
      jump(32'hFFFF_FFF8);
      idle(); idle(); idle(); idle();

      // Reset while a redirect is parked: no jump afterwards.
      jump(32'h0000_3000);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3200);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3300);
      idle(); idle();
      chk("rst_pend_im", fi.im_addr, 32'h0000_3008);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 9))
            0:       t = $urandom;
            1:       t = RESET_PC + 32'(4 * $urandom_range(0, IM_WORDS - 1)) + 32'd2;
            2:       t = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;
            default: t = RESET_PC + 32'(4 * $urandom_range(0, IM_WORDS - 1));
         endcase
         rn = ($urandom_range(0, 99) != 0);
         s  = ($urandom_range(0, 9) < 3);
         f  = ($urandom_range(0, 9) == 0);
         r  = ($urandom_range(0, 9) < 2);
         cycle(rn, s, f, r, t);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
